// File: rtl/packet_arbiter_rr.sv
// Packet-atomic N:1 arbiter (strict priority or round-robin) with a 2-entry
// registered output buffer that isolates out_ready from the input ready paths.

package packet_mux_pkg;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned EMPTY_W = 2;
endpackage

module packet_arbiter_rr #(
    parameter int unsigned N_PORTS  = 4,
    parameter int unsigned DATA_W   = packet_mux_pkg::DATA_W,
    parameter int unsigned EMPTY_W  = packet_mux_pkg::EMPTY_W,
    parameter int unsigned ARB_MODE = 1,
    parameter int unsigned ID_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS*DATA_W-1:0]  in_data,
    input  logic [N_PORTS-1:0]         in_valid,
    input  logic [N_PORTS-1:0]         in_sop,
    input  logic [N_PORTS-1:0]         in_eop,
    input  logic [N_PORTS*EMPTY_W-1:0] in_empty,
    input  logic [N_PORTS-1:0]         in_error,
    output logic [N_PORTS-1:0]         in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [EMPTY_W-1:0]         out_empty,
    output logic                       out_error,
    input  logic                       out_ready,
    output logic [ID_W-1:0]            grant_id,
    output logic                       grant_active,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int unsigned BEAT_W = DATA_W + EMPTY_W + 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOCK = 2'd1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_d;
    logic                grant_active_d;
    logic [BEAT_W-1:0]   head_q, skid_q, beat_in;
    logic                skid_valid_q;
    logic                buf_ok, pop, push, drop;
    logic [ID_W-1:0]     sel, win_idx, orph_idx;
    logic                win_found, orph_found;
    logic [N_PORTS-1:0]  cand, orphan;
    int unsigned         base;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (32'(id) + 32'd1 == N_PORTS) ? '0 : id + ID_W'(1);
    endfunction

    assign cand   = in_valid & in_sop;
    assign orphan = in_valid & ~in_sop;
    assign buf_ok = !(out_valid && skid_valid_q);
    assign pop    = out_valid && out_ready;
    assign base   = (ARB_MODE != 0) ? 32'(rr_ptr_q) : 32'd0;

    // SOP winner search from base (rotating in RR mode) and lowest-index orphan
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        orph_found = 1'b0;
        orph_idx   = '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (!win_found && cand[ID_W'((base + k) % N_PORTS)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'((base + k) % N_PORTS);
            end
            if (!orph_found && orphan[k]) begin
                orph_found = 1'b1;
                orph_idx   = ID_W'(k);
            end
        end
    end

    // Next-state, grant bookkeeping and per-port ready
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id;
        grant_active_d = grant_active;
        in_ready       = '0;
        push           = 1'b0;
        drop           = 1'b0;
        sel            = grant_id;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    sel               = win_idx;
                    in_ready[win_idx] = buf_ok;
                    push              = buf_ok;
                    if (buf_ok) begin
                        if (in_eop[win_idx]) begin
                            if (ARB_MODE != 0) rr_ptr_d = next_id(win_idx);
                        end else begin
                            state_d        = S_LOCK;
                            grant_id_d     = win_idx;
                            grant_active_d = 1'b1;
                        end
                    end
                end
                if (orph_found) begin
                    in_ready[orph_idx] = 1'b1;
                    drop               = 1'b1;
                end
            end
            S_LOCK: begin
                in_ready[grant_id] = buf_ok;
                push               = in_valid[grant_id] && buf_ok;
                if (push && in_eop[grant_id]) begin
                    state_d        = S_IDLE;
                    grant_active_d = 1'b0;
                    if (ARB_MODE != 0) rr_ptr_d = next_id(grant_id);
                end
            end
            default: begin
                state_d        = S_IDLE;
                grant_active_d = 1'b0;
            end
        endcase
        if (rst) in_ready = '0;
    end

    assign beat_in = {in_error[sel],
                      in_empty[32'(sel)*EMPTY_W +: EMPTY_W],
                      in_eop[sel],
                      in_sop[sel],
                      in_data[32'(sel)*DATA_W +: DATA_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id     <= grant_id_d;
            grant_active <= grant_active_d;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // Head register drives out_*; skid catches one beat while the head stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            skid_q       <= '0;
            out_valid    <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid || pop) begin
            if (skid_valid_q) begin
                head_q       <= skid_q;
                out_valid    <= 1'b1;
                skid_valid_q <= push;
                if (push) skid_q <= beat_in;
            end else begin
                out_valid <= push;
                if (push) head_q <= beat_in;
            end
        end else if (push) begin
            skid_q       <= beat_in;
            skid_valid_q <= 1'b1;
        end
    end

    assign {out_error, out_empty, out_eop, out_sop, out_data} = head_q;

endmodule

// File: tb/tb_packet_arbiter_rr.sv
// Scoreboard bench: u_rr (round-robin) is slot 0, u_sp (strict priority) is slot 1.
module tb_packet_arbiter_rr;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = packet_mux_pkg::DATA_W;
    localparam int unsigned EW = packet_mux_pkg::EMPTY_W;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic          err;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*DW-1:0] in_data  [2];
    logic [N-1:0]    in_valid [2];
    logic [N-1:0]    in_sop   [2];
    logic [N-1:0]    in_eop   [2];
    logic [N*EW-1:0] in_empty [2];
    logic [N-1:0]    in_error [2];
    logic [N-1:0]    in_ready [2];
    logic [DW-1:0]   out_data [2];
    logic            out_valid[2];
    logic            out_sop  [2];
    logic            out_eop  [2];
    logic [EW-1:0]   out_empty[2];
    logic            out_error[2];
    logic            out_ready[2];
    logic [1:0]      grant_id [2];
    logic            grant_active[2];
    logic [15:0]     drop_cnt [2];

    packet_arbiter_rr #(.N_PORTS(N), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_sop(in_sop[0]), .in_eop(in_eop[0]),
        .in_empty(in_empty[0]), .in_error(in_error[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_sop(out_sop[0]), .out_eop(out_eop[0]),
        .out_empty(out_empty[0]), .out_error(out_error[0]), .out_ready(out_ready[0]),
        .grant_id(grant_id[0]), .grant_active(grant_active[0]), .drop_cnt(drop_cnt[0])
    );

    packet_arbiter_rr #(.N_PORTS(N), .ARB_MODE(0)) u_sp (
        .clk(clk), .rst(rst),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_sop(in_sop[1]), .in_eop(in_eop[1]),
        .in_empty(in_empty[1]), .in_error(in_error[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_sop(out_sop[1]), .out_eop(out_eop[1]),
        .out_empty(out_empty[1]), .out_error(out_error[1]), .out_ready(out_ready[1]),
        .grant_id(grant_id[1]), .grant_active(grant_active[1]), .drop_cnt(drop_cnt[1])
    );

    int    checks = 0;
    int    errors = 0;
    beat_t exp0[$];
    beat_t exp1[$];
    beat_t src    [2][N][16];
    int    src_n  [2][N];
    int    src_h  [2][N];
    int    src_dly[2][N];
    int    cyc, gaps;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic beat_t mk(input int p, input int k, input int b, input int n, input int xsop);
        beat_t t;
        t.data  = DW'(32'hC000_0000 | (p << 8) | (k << 4) | b);
        t.sop   = (b == 0) || (b == xsop);
        t.eop   = (b == n - 1);
        t.empty = t.eop ? EW'(p) : '0;
        t.err   = t.eop && (p == 3);
        return t;
    endfunction

    task automatic load_pkt(input int d, input int p, input int k, input int n, input int xsop);
        for (int b = 0; b < n; b++) begin
            src[d][p][src_n[d][p]] = mk(p, k, b, n, xsop);
            src_n[d][p]++;
        end
    endtask

    task automatic load_orphans(input int d, input int p, input int n);
        beat_t t;
        for (int b = 0; b < n; b++) begin
            t     = mk(p, 9, b, n, -1);
            t.sop = 1'b0;
            src[d][p][src_n[d][p]] = t;
            src_n[d][p]++;
        end
    endtask

    task automatic expect_pkt(input int d, input int p, input int k, input int n, input int xsop);
        for (int b = 0; b < n; b++) begin
            if (d == 0) exp0.push_back(mk(p, k, b, n, xsop));
            else        exp1.push_back(mk(p, k, b, n, xsop));
        end
    endtask

    task automatic drive_all();
        beat_t t;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < N; p++) begin
                if (src_dly[d][p] > 0) begin
                    src_dly[d][p]--;
                    in_valid[d][p] = 1'b0;
                end else if (src_h[d][p] < src_n[d][p]) begin
                    t = src[d][p][src_h[d][p]];
                    in_valid[d][p]         = 1'b1;
                    in_sop[d][p]           = t.sop;
                    in_eop[d][p]           = t.eop;
                    in_error[d][p]         = t.err;
                    in_data[d][p*DW +: DW]  = t.data;
                    in_empty[d][p*EW +: EW] = t.empty;
                end else begin
                    in_valid[d][p] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        bit acc[2][N];
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < N; p++)
                acc[d][p] = in_valid[d][p] && in_ready[d][p];
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < N; p++)
                if (acc[d][p]) src_h[d][p]++;
        drive_all();
        #1;
    endtask

    function automatic bit all_done();
        bit ok = (exp0.size() == 0) && (exp1.size() == 0);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < N; p++)
                if (src_h[d][p] < src_n[d][p]) ok = 1'b0;
        return ok;
    endfunction

    task automatic drain(input int budget, output int n, output int g);
        bit started = 1'b0;
        n = 0;
        g = 0;
        while (!all_done() && n < budget) begin
            step();
            n++;
            if (out_valid[0]) started = 1'b1;
            else if (started && exp0.size() > 0) g++;
        end
        chk("drain_done", 32'(all_done()), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < N; p++) begin
                src_n[d][p] = 0; src_h[d][p] = 0; src_dly[d][p] = 0;
            end
        drive_all();
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic mon_pop(input int d);
        beat_t act, want;
        act.data  = out_data[d];
        act.sop   = out_sop[d];
        act.eop   = out_eop[d];
        act.empty = out_empty[d];
        act.err   = out_error[d];
        checks++;
        if ((d == 0 && exp0.size() == 0) || (d == 1 && exp1.size() == 0)) begin
            errors++;
            $display("FAIL out%0d_unexpected: got %h, nothing expected", d, act);
        end else begin
            if (d == 0) want = exp0.pop_front();
            else        want = exp1.pop_front();
            if (act !== want) begin
                errors++;
                $display("FAIL out%0d_beat: got %h expected %h", d, act, want);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            if (!rst && out_valid[d] === 1'b1 && out_ready[d] === 1'b1) mon_pop(d);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_data[d] = '0; in_empty[d] = '0; in_error[d] = '0; in_eop[d] = '0;
            in_valid[d] = '1; in_sop[d] = '1; out_ready[d] = 1'b1;
        end
        // reset state with every port requesting
        @(posedge clk);
        #2;
        chk("rst_in_ready0", 32'(in_ready[0]), 0);
        chk("rst_in_ready1", 32'(in_ready[1]), 0);
        chk("rst_out_valid", 32'(out_valid[0]), 0);
        chk("rst_out_data", out_data[0], 0);
        chk("rst_grant_active", 32'(grant_active[0]), 0);
        chk("rst_grant_id", 32'(grant_id[0]), 0);
        chk("rst_drop_cnt", 32'(drop_cnt[0]), 0);
        do_reset();

        // single beat on port 2, then RR pointer must favour 3 over 0
        load_pkt(0, 2, 0, 1, -1);
        expect_pkt(0, 2, 0, 1, -1);
        drive_all();
        step();
        chk("single_latency", 32'(out_valid[0]), 1);
        chk("single_no_grant", 32'(grant_active[0]), 0);
        load_pkt(0, 0, 1, 1, -1);
        load_pkt(0, 3, 1, 1, -1);
        expect_pkt(0, 3, 1, 1, -1);
        expect_pkt(0, 0, 1, 1, -1);
        drive_all();
        drain(20, cyc, gaps);

        // RR fairness: every port has two back-to-back 3-beat packets
        do_reset();
        for (int p = 0; p < N; p++) begin
            load_pkt(0, p, 0, 3, -1);
            load_pkt(0, p, 1, 3, -1);
        end
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < N; p++)
                expect_pkt(0, p, k, 3, -1);
        drive_all();
        drain(60, cyc, gaps);
        chk("rr_cycles", 32'(cyc), 25);
        chk("rr_gaps", 32'(gaps), 0);

        // strict priority: 1 and 3 race, 0 arrives mid-packet with a stray SOP inside port 1
        do_reset();
        load_pkt(1, 1, 2, 4, 2);
        load_pkt(1, 3, 2, 2, -1);
        load_pkt(1, 0, 2, 2, -1);
        src_dly[1][0] = 2;
        expect_pkt(1, 1, 2, 4, 2);
        expect_pkt(1, 0, 2, 2, -1);
        expect_pkt(1, 3, 2, 2, -1);
        drive_all();
        step();
        chk("sp_grant_active", 32'(grant_active[1]), 1);
        chk("sp_grant_id", 32'(grant_id[1]), 1);
        chk("sp_port3_blocked", 32'(in_ready[1][3]), 0);
        drain(40, cyc, gaps);

        // backpressure: 5 stalled cycles during a 6-beat packet
        do_reset();
        out_ready[0] = 1'b0;
        load_pkt(0, 0, 3, 6, -1);
        expect_pkt(0, 0, 3, 6, -1);
        drive_all();
        step();
        step();
        chk("bp_full_ready", 32'(in_ready[0][0]), 0);
        chk("bp_head_data", out_data[0], mk(0, 3, 0, 6, -1).data);
        repeat (3) step();
        chk("bp_hold_valid", 32'(out_valid[0]), 1);
        chk("bp_hold_data", out_data[0], mk(0, 3, 0, 6, -1).data);
        chk("bp_hold_sop", 32'(out_sop[0]), 1);
        chk("bp_still_full", 32'(in_ready[0][0]), 0);
        chk("bp_accepted", 32'(src_h[0][0]), 2);
        out_ready[0] = 1'b1;
        drain(30, cyc, gaps);

        // orphans on ports 1 and 3 alongside a single-beat SOP on port 2
        do_reset();
        load_orphans(0, 1, 3);
        load_orphans(0, 3, 2);
        load_pkt(0, 2, 5, 1, -1);
        expect_pkt(0, 2, 5, 1, -1);
        drive_all();
        drain(20, cyc, gaps);
        chk("orphan_drop_cnt", 32'(drop_cnt[0]), 5);
        chk("orphan_idle", 32'(out_valid[0]), 0);
        in_valid[0][1] = 1'b1;
        in_sop[0][1]   = 1'b0;
        repeat (65529) @(posedge clk);
        #2 chk("drop_cnt_fffe", 32'(drop_cnt[0]), 32'hFFFE);
        @(posedge clk);
        #2 chk("drop_cnt_ffff", 32'(drop_cnt[0]), 32'hFFFF);
        repeat (5) @(posedge clk);
        #2 chk("drop_cnt_sat", 32'(drop_cnt[0]), 32'hFFFF);
        in_valid[0][1] = 1'b0;

        // reset after beat 2 of 4, then a fresh packet from port 0
        out_ready[0] = 1'b0;
        load_pkt(0, 0, 7, 4, -1);
        drive_all();
        step();
        step();
        chk("mr_locked", 32'(grant_active[0]), 1);
        rst = 1'b1;
        for (int p = 0; p < N; p++) src_h[0][p] = src_n[0][p];
        drive_all();
        step();
        rst = 1'b0;
        chk("mr_out_valid", 32'(out_valid[0]), 0);
        chk("mr_grant_active", 32'(grant_active[0]), 0);
        chk("mr_drop_cnt", 32'(drop_cnt[0]), 0);
        out_ready[0] = 1'b1;
        load_pkt(0, 0, 8, 3, -1);
        expect_pkt(0, 0, 8, 3, -1);
        drive_all();
        drain(20, cyc, gaps);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
